ifu_fetch_master: RTL and testbench

//  Instruction-fetch front end: holds the PC and issues one AXI-lite read per instruction
//  to the instruction SRAM slave. Extracts the 32-bit instruction from the 64-bit read beat
//  and hands {pc, inst} to decode over a valid/ready handshake.

---
 rtl/ifu_fetch_master.sv | 174 +++++++++++++++++
 tb/tb_ifu_fetch_master.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_master.sv
// Instruction-fetch front end: holds the PC, issues one AXI-lite read per instruction,
// picks the 32-bit word out of the 64-bit beat and presents {inst_pc, inst} to decode.
// Latency: arvalid handshake -> inst_valid in 2 cycles; at least 3 cycles per instruction.
// Backpressure: inst_ready low holds the instruction in HOLD with no new read issued.
//
// Ports:
//   clk, rst_n                 clock and synchronous active-low reset
//   araddr/arvalid/arready     read address channel to the instruction SRAM
//   rdata/rvalid/rready/rresp  read data channel (8-byte beat holding the PC's word)
//   redirect/redirect_pc       one-cycle flush-and-refetch request from execute
//   inst_valid/inst_ready      handshake to decode
//   inst/inst_pc/fetch_err     instruction word, its PC, and non-OKAY response flag
module ifu_fetch_master #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [63:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    input  logic [1:0]  rresp,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        ADDR = 2'd0,
        RESP = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state_q,      state_n;
    logic [31:0] pc_q,         pc_n;
    logic [31:0] araddr_q,     araddr_n;
    logic        arvalid_q,    arvalid_n;
    logic        discard_q,    discard_n;
    logic        inst_valid_q, inst_valid_n;
    logic [31:0] inst_q,       inst_n;
    logic [31:0] inst_pc_q,    inst_pc_n;
    logic        fetch_err_q,  fetch_err_n;

    logic [31:0] redirect_tgt;

    // Fetch addresses are always word aligned.
    assign redirect_tgt = redirect_pc & ~32'h3;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ADDR;
            pc_q         <= RESET_PC & ~32'h3;
            araddr_q     <= RESET_PC & ~32'h3;
            arvalid_q    <= 1'b0;
            discard_q    <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_q       <= 32'h0;
            inst_pc_q    <= 32'h0;
            fetch_err_q  <= 1'b0;
        end else begin
            state_q      <= state_n;
            pc_q         <= pc_n;
            araddr_q     <= araddr_n;
            arvalid_q    <= arvalid_n;
            discard_q    <= discard_n;
            inst_valid_q <= inst_valid_n;
            inst_q       <= inst_n;
            inst_pc_q    <= inst_pc_n;
            fetch_err_q  <= fetch_err_n;
        end
    end

    always_comb begin
        state_n      = state_q;
        pc_n         = pc_q;
        araddr_n     = araddr_q;
        arvalid_n    = arvalid_q;
        discard_n    = discard_q;
        inst_valid_n = inst_valid_q;
        inst_n       = inst_q;
        inst_pc_n    = inst_pc_q;
        fetch_err_n  = fetch_err_q;

        unique case (state_q)
            ADDR: begin
                if (!arvalid_q) begin
                    // Only reached on the first cycle out of reset: nothing is on the
                    // bus yet, so a redirect simply changes what gets issued.
                    arvalid_n = 1'b1;
                    if (redirect) begin
                        pc_n     = redirect_tgt;
                        araddr_n = redirect_tgt;
                    end else begin
                        araddr_n = pc_q;
                    end
                end else begin
                    if (arready) begin
                        arvalid_n = 1'b0;
                        state_n   = RESP;
                    end
                    // The request already on the bus cannot be withdrawn or altered;
                    // let it complete and throw its beat away.
                    if (redirect) begin
                        pc_n      = redirect_tgt;
                        discard_n = 1'b1;
                    end
                end
            end

            RESP: begin
                if (rvalid) begin
                    if (redirect || discard_q) begin
                        // Stale beat: drop it and refetch from the newest target.
                        discard_n = 1'b0;
                        state_n   = ADDR;
                        arvalid_n = 1'b1;
                        if (redirect) begin
                            pc_n     = redirect_tgt;
                            araddr_n = redirect_tgt;
                        end else begin
                            araddr_n = pc_q;
                        end
                    end else begin
                        inst_n       = pc_q[2] ? rdata[63:32] : rdata[31:0];
                        inst_pc_n    = pc_q;
                        fetch_err_n  = (rresp != 2'b00);
                        inst_valid_n = 1'b1;
                        pc_n         = pc_q + 32'd4;
                        state_n      = HOLD;
                    end
                end else if (redirect) begin
                    pc_n      = redirect_tgt;
                    discard_n = 1'b1;
                end
            end

            HOLD: begin
                if (redirect) begin
                    // Squash wins over a same-cycle decode accept.
                    inst_valid_n = 1'b0;
                    pc_n         = redirect_tgt;
                    araddr_n     = redirect_tgt;
                    arvalid_n    = 1'b1;
                    state_n      = ADDR;
                end else if (inst_ready) begin
                    inst_valid_n = 1'b0;
                    araddr_n     = pc_q;
                    arvalid_n    = 1'b1;
                    state_n      = ADDR;
                end
            end

            default: begin
                state_n   = ADDR;
                arvalid_n = 1'b0;
            end
        endcase
    end

    assign araddr     = araddr_q;
    assign arvalid    = arvalid_q;
    assign rready     = (state_q == RESP);
    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign fetch_err  = fetch_err_q;

endmodule

// File: tb/tb_ifu_fetch_master.sv
// Directed bench for ifu_fetch_master: per-cycle vector table plus a short
// hand-written double-redirect sequence and an accepted-instruction scoreboard.
module tb_ifu_fetch_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [63:0] rdata;
    logic        rvalid;
    logic        rready;
    logic [1:0]  rresp;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fetch_err;

    int errors = 0;
    int checks = 0;

    logic [31:0] accepted_q[$];

    always #5 clk = ~clk;

    ifu_fetch_master #(.RESET_PC(32'h8000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .araddr      (araddr),
        .arvalid     (arvalid),
        .arready     (arready),
        .rdata       (rdata),
        .rvalid      (rvalid),
        .rready      (rready),
        .rresp       (rresp),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .fetch_err   (fetch_err)
    );

    // Decode-side scoreboard: a transfer counts only when not squashed by redirect.
    always @(posedge clk) begin
        if (rst_n && inst_valid && inst_ready && !redirect)
            accepted_q.push_back(inst_pc);
    end

    typedef struct {
        logic        rst_n;
        logic        arready;
        logic        rvalid;
        logic [63:0] rdata;
        logic [1:0]  rresp;
        logic        redirect;
        logic [31:0] redirect_pc;
        logic        inst_ready;
        logic        chk;
        logic        e_arvalid;
        logic [31:0] e_araddr;
        logic        e_rready;
        logic        e_inst_valid;
        logic [31:0] e_inst;
        logic [31:0] e_inst_pc;
        logic        e_fetch_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rs, logic ard, logic rv, logic [63:0] rd, logic [1:0] rr,
                                logic rdr, logic [31:0] rpc, logic ir, logic ck,
                                logic e_arv, logic [31:0] e_ara, logic e_rr, logic e_iv,
                                logic [31:0] e_in, logic [31:0] e_ip, logic e_er);
        vec_t v;
        v.rst_n = rs; v.arready = ard; v.rvalid = rv; v.rdata = rd; v.rresp = rr;
        v.redirect = rdr; v.redirect_pc = rpc; v.inst_ready = ir; v.chk = ck;
        v.e_arvalid = e_arv; v.e_araddr = e_ara; v.e_rready = e_rr; v.e_inst_valid = e_iv;
        v.e_inst = e_in; v.e_inst_pc = e_ip; v.e_fetch_err = e_er;
        return v;
    endfunction

    task automatic check(input string name, input int row, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic drive(input logic rs, input logic ard, input logic rv, input logic [63:0] rd,
                         input logic [1:0] rr, input logic rdr, input logic [31:0] rpc,
                         input logic ir);
        rst_n = rs; arready = ard; rvalid = rv; rdata = rd; rresp = rr;
        redirect = rdr; redirect_pc = rpc; inst_ready = ir;
    endtask

    localparam logic [63:0] D0 = 64'h00100093_00000413;
    localparam logic [63:0] DX = 64'hDEADBEEF_CAFEF00D;
    localparam logic [63:0] D1 = 64'h11111111_22222222;
    localparam logic [63:0] D2 = 64'h33333333_44444444;
    localparam logic [63:0] D3 = 64'h55555555_66666666;
    localparam logic [63:0] D4 = 64'h77777777_88888888;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b0, 1'b0, 1'b0, 64'h0, 2'b00, 1'b0, 32'h0, 1'b0);

        // rst ard rv rdata rresp redir rpc ir chk | arv araddr rr iv inst inst_pc err
        // Reset, then back-to-back fetches of one line (lower then upper word).
        vecs.push_back(mk(0,1,1,D0,0,0,0,1, 0, 0,32'h80000000,0,0,32'h0,32'h0,0));
        vecs.push_back(mk(0,1,1,D0,0,0,0,1, 1, 0,32'h80000000,0,0,32'h0,32'h0,0));
        vecs.push_back(mk(1,1,1,D0,0,0,0,1, 1, 0,32'h80000000,0,0,32'h0,32'h0,0));
        vecs.push_back(mk(1,1,1,D0,0,0,0,1, 1, 1,32'h80000000,0,0,32'h0,32'h0,0));
        vecs.push_back(mk(1,1,1,D0,0,0,0,1, 1, 0,32'h80000000,1,0,32'h0,32'h0,0));
        vecs.push_back(mk(1,1,1,D0,0,0,0,1, 1, 0,32'h80000000,0,1,32'h00000413,32'h80000000,0));
        vecs.push_back(mk(1,1,1,D0,0,0,0,1, 1, 1,32'h80000004,0,0,32'h00000413,32'h80000000,0));
        vecs.push_back(mk(1,1,1,D0,0,0,0,1, 1, 0,32'h80000004,1,0,32'h00000413,32'h80000000,0));
        // Decode stalls five cycles in HOLD.
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1,1,1,D0,0,0,0,0, 1, 0,32'h80000004,0,1,32'h00100093,32'h80000004,0));
        vecs.push_back(mk(1,1,1,D0,0,0,0,1, 1, 0,32'h80000004,0,1,32'h00100093,32'h80000004,0));
        // arready low for 3 cycles, redirect in the middle: address must hold.
        vecs.push_back(mk(1,0,0,D0,0,0,0,1, 1, 1,32'h80000008,0,0,32'h00100093,32'h80000004,0));
        vecs.push_back(mk(1,0,0,D0,0,1,32'h80001000,1, 1, 1,32'h80000008,0,0,32'h00100093,32'h80000004,0));
        vecs.push_back(mk(1,0,0,D0,0,0,0,1, 1, 1,32'h80000008,0,0,32'h00100093,32'h80000004,0));
        vecs.push_back(mk(1,1,0,D0,0,0,0,1, 1, 1,32'h80000008,0,0,32'h00100093,32'h80000004,0));
        vecs.push_back(mk(1,0,1,DX,0,0,0,1, 1, 0,32'h80000008,1,0,32'h00100093,32'h80000004,0));
        vecs.push_back(mk(1,1,0,DX,0,0,0,1, 1, 1,32'h80001000,0,0,32'h00100093,32'h80000004,0));
        // Redirect coincident with rvalid in RESP; upper word of next line selected.
        vecs.push_back(mk(1,0,1,DX,0,1,32'h80000204,1, 1, 0,32'h80001000,1,0,32'h00100093,32'h80000004,0));
        vecs.push_back(mk(1,1,0,DX,0,0,0,1, 1, 1,32'h80000204,0,0,32'h00100093,32'h80000004,0));
        vecs.push_back(mk(1,0,1,D1,0,0,0,0, 1, 0,32'h80000204,1,0,32'h00100093,32'h80000004,0));
        // Redirect in HOLD with inst_ready=1: squashed.
        vecs.push_back(mk(1,0,0,D1,0,1,32'h80000400,1, 1, 0,32'h80000204,0,1,32'h11111111,32'h80000204,0));
        vecs.push_back(mk(1,1,0,D1,0,0,0,1, 1, 1,32'h80000400,0,0,32'h11111111,32'h80000204,0));
        // Error response on one beat, OKAY on the next.
        vecs.push_back(mk(1,0,1,D2,2,0,0,1, 1, 0,32'h80000400,1,0,32'h11111111,32'h80000204,0));
        vecs.push_back(mk(1,0,0,D2,0,0,0,1, 1, 0,32'h80000400,0,1,32'h44444444,32'h80000400,1));
        vecs.push_back(mk(1,1,0,D2,0,0,0,1, 1, 1,32'h80000404,0,0,32'h44444444,32'h80000400,1));
        vecs.push_back(mk(1,0,1,D2,0,0,0,1, 1, 0,32'h80000404,1,0,32'h44444444,32'h80000400,1));
        // Redirect to an unaligned top-of-memory target, then wrap to zero.
        vecs.push_back(mk(1,0,0,D2,0,1,32'hFFFFFFFF,0, 1, 0,32'h80000404,0,1,32'h33333333,32'h80000404,0));
        vecs.push_back(mk(1,1,0,D3,0,0,0,1, 1, 1,32'hFFFFFFFC,0,0,32'h33333333,32'h80000404,0));
        vecs.push_back(mk(1,0,1,D3,0,0,0,1, 1, 0,32'hFFFFFFFC,1,0,32'h33333333,32'h80000404,0));
        vecs.push_back(mk(1,0,0,D3,0,0,0,1, 1, 0,32'hFFFFFFFC,0,1,32'h55555555,32'hFFFFFFFC,0));
        vecs.push_back(mk(1,0,0,D3,0,0,0,0, 1, 1,32'h00000000,0,0,32'h55555555,32'hFFFFFFFC,0));
        // Reset mid-request; stray rvalid afterwards is ignored.
        vecs.push_back(mk(0,0,1,D3,0,0,0,0, 1, 1,32'h00000000,0,0,32'h55555555,32'hFFFFFFFC,0));
        vecs.push_back(mk(1,0,1,D3,0,0,0,0, 1, 0,32'h80000000,0,0,32'h0,32'h0,0));
        vecs.push_back(mk(1,0,1,D3,0,0,0,0, 1, 1,32'h80000000,0,0,32'h0,32'h0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].rst_n, vecs[i].arready, vecs[i].rvalid, vecs[i].rdata, vecs[i].rresp,
                  vecs[i].redirect, vecs[i].redirect_pc, vecs[i].inst_ready);
            #1;
            if (vecs[i].chk) begin
                check("arvalid",    i, {31'b0, arvalid},    {31'b0, vecs[i].e_arvalid});
                check("araddr",     i, araddr,              vecs[i].e_araddr);
                check("rready",     i, {31'b0, rready},     {31'b0, vecs[i].e_rready});
                check("inst_valid", i, {31'b0, inst_valid}, {31'b0, vecs[i].e_inst_valid});
                check("inst",       i, inst,                vecs[i].e_inst);
                check("inst_pc",    i, inst_pc,             vecs[i].e_inst_pc);
                check("fetch_err",  i, {31'b0, fetch_err},  {31'b0, vecs[i].e_fetch_err});
            end
        end

        // Two redirects while a request is pending: only the newest target is fetched.
        @(negedge clk);
        drive(1, 0, 0, D4, 0, 1, 32'h80002000, 0);
        #1;
        check("dbl_arvalid_a", 100, {31'b0, arvalid}, 32'h1);
        check("dbl_araddr_a",  100, araddr, 32'h80000000);
        @(negedge clk);
        drive(1, 1, 0, D4, 0, 1, 32'h80003000, 0);
        #1;
        check("dbl_araddr_b",  101, araddr, 32'h80000000);
        @(negedge clk);
        drive(1, 0, 1, D4, 0, 0, 32'h0, 0);
        #1;
        check("dbl_rready_c",  102, {31'b0, rready}, 32'h1);
        @(negedge clk);
        drive(1, 1, 0, D4, 0, 0, 32'h0, 0);
        #1;
        check("dbl_iv_d",      103, {31'b0, inst_valid}, 32'h0);
        check("dbl_arvalid_d", 103, {31'b0, arvalid}, 32'h1);
        check("dbl_araddr_d",  103, araddr, 32'h80003000);
        @(negedge clk);
        drive(1, 0, 1, D4, 0, 0, 32'h0, 0);
        #1;
        check("dbl_rready_e",  104, {31'b0, rready}, 32'h1);
        @(negedge clk);
        drive(1, 0, 0, D4, 0, 0, 32'h0, 0);
        #1;
        check("dbl_iv_f",      105, {31'b0, inst_valid}, 32'h1);
        check("dbl_inst_f",    105, inst, 32'h88888888);
        check("dbl_pc_f",      105, inst_pc, 32'h80003000);

        // Scoreboard: PCs of instructions decode actually accepted.
        begin
            logic [31:0] exp_acc[4];
            exp_acc[0] = 32'h80000000;
            exp_acc[1] = 32'h80000004;
            exp_acc[2] = 32'h80000400;
            exp_acc[3] = 32'hFFFFFFFC;
            check("accept_count", 200, accepted_q.size(), 32'd4);
            for (int k = 0; k < 4; k++) begin
                if (k < accepted_q.size())
                    check("accept_pc", 200 + k, accepted_q[k], exp_acc[k]);
                else
                    check("accept_pc", 200 + k, 32'hxxxxxxxx, exp_acc[k]);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
